dcache_axi_read_arbiter: RTL

- Shares the single core AXI read channel (AR + R) among REQ_NUM read masters: DCache miss unit at index 0, PTW at index 1, ICache at index 2.
- Round-robin arbitration over AR; one registered AR output slot; at most one outstanding burst per requester.
- Routes R beats back to the owner by ID.
- Sits between the cache/PTW refill engines and the memory-side AXI crossbar.

---
 rtl/dcache_axi_read_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dcache_axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel (AR + R) among REQ_NUM refill masters.
// Optional DCACHE_ARB_CHECK_EN adds per-requester beat counters and a sticky err output.
module dcache_axi_read_arbiter #(
  parameter int REQ_NUM = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int IDX_W   = $clog2(REQ_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REQ_NUM-1:0]        req_arvalid,
  output logic [REQ_NUM-1:0]        req_arready,
  input  logic [REQ_NUM*ADDR_W-1:0] req_araddr,
  input  logic [REQ_NUM*8-1:0]      req_arlen,
  output logic [REQ_NUM-1:0]        req_rvalid,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      req_rlast,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [7:0]                m_arlen,
  output logic [IDX_W-1:0]          m_arid,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [IDX_W-1:0]          m_rid,
  input  logic                      m_rlast,
  output logic [REQ_NUM-1:0]        pending,
`ifdef DCACHE_ARB_CHECK_EN
  output logic                      err,
`endif
  output logic                      dbg_slot_full,
  output logic [IDX_W-1:0]          dbg_rr
);

  // Handshake: a transfer happens on a clock edge where valid and ready are both high;
  // valid never waits on ready, and the payload is held stable while valid && !ready.

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_e;

  slot_state_e          slot_state;
  logic [IDX_W-1:0]     rr;
  logic [REQ_NUM-1:0]   elig;
  logic [REQ_NUM-1:0]   grant;
  logic [REQ_NUM-1:0]   rlast_clr;
  logic [IDX_W-1:0]     winner;
  logic                 found;
  logic [IDX_W-1:0]     rr_next;

  assign elig          = req_arvalid & ~pending;
  assign m_arvalid     = (slot_state == SLOT_FULL);
  assign dbg_slot_full = (slot_state == SLOT_FULL);
  assign dbg_rr        = rr;
  assign req_arready   = grant;
  assign m_rready      = 1'b1;
  assign req_rdata     = m_rdata;
  assign req_rlast     = m_rlast;

  // Scan rr, rr+1, ... with explicit modulo so non-power-of-two REQ_NUM wraps correctly.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < REQ_NUM; k++) begin
      idx = int'(rr) + k;
      if (idx >= REQ_NUM) idx = idx - REQ_NUM;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
    if (slot_state == SLOT_FULL) found = 1'b0;
    grant = '0;
    if (found) grant[winner] = 1'b1;
  end

  assign rr_next = (winner == IDX_W'(REQ_NUM - 1)) ? '0 : winner + IDX_W'(1);

  always_comb begin
    for (int i = 0; i < REQ_NUM; i++) begin
      req_rvalid[i] = m_rvalid & (m_rid == IDX_W'(i)) & pending[i];
      rlast_clr[i]  = m_rvalid & m_rlast & (m_rid == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_state <= SLOT_EMPTY;
      m_araddr   <= '0;
      m_arlen    <= '0;
      m_arid     <= '0;
      rr         <= '0;
      pending    <= '0;
    end else begin
      case (slot_state)
        SLOT_EMPTY: if (found) begin
          slot_state <= SLOT_FULL;
          m_araddr   <= req_araddr[winner*ADDR_W +: ADDR_W];
          m_arlen    <= req_arlen[winner*8 +: 8];
          m_arid     <= winner;
          rr         <= rr_next;
        end
        SLOT_FULL: if (m_arready) slot_state <= SLOT_EMPTY;
        default: slot_state <= SLOT_EMPTY;
      endcase
      // A grant never targets a pending requester, so set and clear cannot collide.
      pending <= (pending & ~rlast_clr) | grant;
    end
  end

`ifdef DCACHE_ARB_CHECK_EN
  logic [7:0] beat_cnt [REQ_NUM];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
      for (int i = 0; i < REQ_NUM; i++) beat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (grant[i]) begin
          beat_cnt[i] <= req_arlen[i*8 +: 8];
        end else if (req_rvalid[i]) begin
          if (m_rlast && beat_cnt[i] != 8'd0) begin
            err <= 1'b1;
            $error("dcache_axi_read_arbiter: early rlast for requester %0d", i);
          end else if (!m_rlast && beat_cnt[i] == 8'd0) begin
            err <= 1'b1;
            $error("dcache_axi_read_arbiter: missing rlast for requester %0d", i);
          end else if (!m_rlast) begin
            beat_cnt[i] <= beat_cnt[i] - 8'd1;
          end
        end
      end
      if (m_rvalid && req_rvalid == '0) begin
        err <= 1'b1;
        $error("dcache_axi_read_arbiter: unmatched R beat id %0d", m_rid);
      end
    end
  end
`endif

endmodule
